mem_ctrl: RTL and testbench

- Memory-side responder for the load/store buffer request interface and the instruction-fetch port.
- Arbitrates the two requesters onto the single byte-wide RAM/IO bus.
- Serialises 1/2/4-byte accesses as little-endian byte sequences.
- Returns load data zero-extended; the load/store buffer performs sign extension.

---
 rtl/mem_ctrl.sv | 179 +++++++++++++++++
 tb/tb_mem_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates LSB and instruction-fetch requests
// onto a byte-wide RAM/IO bus, assembling little-endian words for loads and fetches.
module mem_ctrl #(
  parameter int unsigned ADDR_W = 32,
  parameter logic [1:0]  IO_HI  = 2'b11
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              clear_in,
  input  logic              go_work,
  input  logic              l_or_s,
  input  logic [2:0]        width,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       value_store,
  output logic              received,
  output logic              has_result,
  output logic [31:0]       value_load,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [31:0]       if_data,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              io_buffer_full
);

  typedef enum logic [1:0] {IDLE, LREAD, LWRITE, FETCH} state_t;

  state_t            state;
  logic [ADDR_W-1:0] base;
  logic [2:0]        cnt;
  logic [2:0]        nbytes;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic [1:0]        guard;
  logic              resync;
  logic              bad;
  logic              wr_q;

  logic              lsb_go;
  logic              width_ok;
  logic [ADDR_W-1:0] cur_a;
  logic [ADDR_W-1:0] next_a;
  logic              io_block;
  logic              acc_io_block;
  logic [7:0]        wbyte;
  logic [31:0]       rd_merge;

  // Pause suppresses the write strobe within the same cycle so no byte lands
  // while the controller is frozen; the registered strobe re-asserts on resume.
  assign mem_wr = wr_q & rdy_in;

  always_comb begin
    lsb_go       = go_work && (guard == 2'd0);
    width_ok     = (width == 3'd1) || (width == 3'd2) || (width == 3'd4);
    cur_a        = base + ADDR_W'(cnt);
    next_a       = cur_a + ADDR_W'(1);
    io_block     = (cur_a[17:16] == IO_HI) && io_buffer_full;
    acc_io_block = (address[17:16] == IO_HI) && io_buffer_full;
    wbyte        = wdata[{cnt[1:0], 3'b000} +: 8];
    rd_merge     = rdata;
    rd_merge[{cnt[1:0], 3'b000} +: 8] = mem_din;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state      <= IDLE;
      base       <= '0;
      cnt        <= '0;
      nbytes     <= '0;
      wdata      <= '0;
      rdata      <= '0;
      guard      <= '0;
      resync     <= 1'b0;
      bad        <= 1'b0;
      wr_q       <= 1'b0;
      received   <= 1'b0;
      has_result <= 1'b0;
      value_load <= '0;
      if_done    <= 1'b0;
      if_data    <= '0;
      mem_dout   <= '0;
      mem_a      <= '0;
    end else begin
      received   <= 1'b0;
      has_result <= 1'b0;
      if_done    <= 1'b0;
      if (!rdy_in) begin
        // The byte on the bus during a pause is not trusted; re-present it first.
        if (state == LREAD || state == FETCH) resync <= 1'b1;
      end else begin
        if (guard != 2'd0) guard <= guard - 2'd1;
        case (state)
          IDLE: begin
            wr_q <= 1'b0;
            if (lsb_go) begin
              received <= 1'b1;
              guard    <= 2'd2;
              base     <= address;
              nbytes   <= width;
              wdata    <= value_store;
              rdata    <= '0;
              cnt      <= '0;
              resync   <= 1'b0;
              bad      <= !width_ok;
              if (!l_or_s) begin
                state <= LREAD;
                if (width_ok) mem_a <= address;
              end else if (width_ok) begin
                state    <= LWRITE;
                mem_a    <= address;
                mem_dout <= value_store[7:0];
                if (!acc_io_block) begin
                  wr_q <= 1'b1;
                  cnt  <= 3'd1;
                end
              end
            end else if (if_req && !clear_in) begin
              state  <= FETCH;
              base   <= if_addr;
              nbytes <= 3'd4;
              rdata  <= '0;
              cnt    <= '0;
              resync <= 1'b0;
              bad    <= 1'b0;
              mem_a  <= if_addr;
            end
          end
          LREAD, FETCH: begin
            if (state == FETCH && clear_in) begin
              state <= IDLE;
            end else if (bad) begin
              has_result <= 1'b1;
              value_load <= '0;
              state      <= IDLE;
            end else if (resync) begin
              resync <= 1'b0;
            end else begin
              rdata <= rd_merge;
              mem_a <= next_a;
              if (cnt == nbytes - 3'd1) begin
                state <= IDLE;
                if (state == FETCH) begin
                  if_done <= 1'b1;
                  if_data <= rd_merge;
                end else begin
                  has_result <= 1'b1;
                  value_load <= rd_merge;
                end
              end else begin
                cnt <= cnt + 3'd1;
              end
            end
          end
          LWRITE: begin
            if (cnt == nbytes) begin
              wr_q  <= 1'b0;
              state <= IDLE;
            end else begin
              mem_a    <= cur_a;
              mem_dout <= wbyte;
              if (io_block) begin
                wr_q <= 1'b0;
              end else begin
                wr_q <= 1'b1;
                cnt  <= cnt + 3'd1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: table of LSB transactions against a byte RAM
// model, plus hand-written sequences for arbitration, IO gating, flush, pause, reset.
module tb_mem_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        clear_in;
  logic        go_work;
  logic        l_or_s;
  logic [2:0]  width;
  logic [31:0] address;
  logic [31:0] value_store;
  logic        received;
  logic        has_result;
  logic [31:0] value_load;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_data;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;

  int n_pass = 0;
  int n_total = 0;

  logic [7:0] ram [0:262143];

  mem_ctrl #(.ADDR_W(32), .IO_HI(2'b11)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
    .go_work(go_work), .l_or_s(l_or_s), .width(width), .address(address),
    .value_store(value_store), .received(received), .has_result(has_result),
    .value_load(value_load), .if_req(if_req), .if_addr(if_addr), .if_done(if_done),
    .if_data(if_data), .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a),
    .mem_wr(mem_wr), .io_buffer_full(io_buffer_full)
  );

  always #5 clk_in = ~clk_in;

  assign mem_din = ram[mem_a[17:0]];
  always @(posedge clk_in) if (mem_wr) ram[mem_a[17:0]] <= mem_dout;

  typedef struct {
    logic        ls;
    logic [2:0]  w;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp;
    int          lat;
    int          nwr;
  } vec_t;

  vec_t vecs[11];

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] a);
    logic [17:0] i;
    i = a[17:0];
    return {ram[i + 18'd3], ram[i + 18'd2], ram[i + 18'd1], ram[i]};
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int lat;
    int nwr;
    int extra;
    logic got;
    logic [31:0] val;
    go_work = 1'b1; l_or_s = v.ls; width = v.w; address = v.a; value_store = v.d;
    tick();
    check($sformatf("v%0d received", idx), {31'b0, received}, 32'd1);
    nwr = mem_wr ? 1 : 0;
    go_work = 1'b0;
    got = 1'b0; lat = 0; extra = 0; val = '0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (received) extra++;
      if (mem_wr) nwr++;
      if (has_result && !got) begin
        got = 1'b1; lat = i; val = value_load;
      end
    end
    check($sformatf("v%0d received_once", idx), extra, 0);
    if (!v.ls) begin
      check($sformatf("v%0d has_result", idx), {31'b0, got}, 32'd1);
      check($sformatf("v%0d latency", idx), lat, v.lat);
      check($sformatf("v%0d value_load", idx), val, v.exp);
    end else begin
      check($sformatf("v%0d no_result", idx), {31'b0, got}, 32'd0);
      check($sformatf("v%0d write_count", idx), nwr, v.nwr);
      check($sformatf("v%0d ram_word", idx), word_at(v.a), v.exp);
    end
  endtask

  initial begin
    int hr_tick;
    int ifd_tick;
    int cnt;
    logic [5:0] rpat;

    vecs[0]  = '{1'b0, 3'd4, 32'h100,      32'h0,        32'h12345678, 4, 0};
    vecs[1]  = '{1'b0, 3'd1, 32'h110,      32'h0,        32'h000000F0, 1, 0};
    vecs[2]  = '{1'b0, 3'd2, 32'h120,      32'h0,        32'h0000ABCD, 2, 0};
    vecs[3]  = '{1'b1, 3'd2, 32'h200,      32'h1234BEEF, 32'h0000BEEF, 0, 2};
    vecs[4]  = '{1'b1, 3'd4, 32'h210,      32'hDEADBEEF, 32'hDEADBEEF, 0, 4};
    vecs[5]  = '{1'b0, 3'd4, 32'h210,      32'h0,        32'hDEADBEEF, 4, 0};
    vecs[6]  = '{1'b0, 3'd3, 32'h100,      32'h0,        32'h00000000, 1, 0};
    vecs[7]  = '{1'b1, 3'd0, 32'h300,      32'h55,       32'h00000000, 0, 0};
    vecs[8]  = '{1'b0, 3'd1, 32'h103,      32'h0,        32'h00000012, 1, 0};
    vecs[9]  = '{1'b0, 3'd2, 32'hFFFFFFFF, 32'h0,        32'h00001311, 2, 0};
    vecs[10] = '{1'b1, 3'd1, 32'h220,      32'h00CAFE77, 32'h00000077, 0, 1};

    for (int i = 0; i < 262144; i++) ram[i] = 8'h00;
    ram[18'h100] = 8'h78; ram[18'h101] = 8'h56; ram[18'h102] = 8'h34; ram[18'h103] = 8'h12;
    ram[18'h110] = 8'hF0;
    ram[18'h120] = 8'hCD; ram[18'h121] = 8'hAB;
    ram[18'h3FFFF] = 8'h11;
    ram[18'h0] = 8'h13;

    rst_in = 1'b0; rdy_in = 1'b1; clear_in = 1'b0; go_work = 1'b0; l_or_s = 1'b0;
    width = 3'd0; address = '0; value_store = '0; if_req = 1'b0; if_addr = '0;
    io_buffer_full = 1'b0;
    idle(2);
    check("reset outputs", {31'b0, received | has_result | if_done | mem_wr}, 32'd0);
    check("reset mem_a", mem_a, 32'd0);
    rst_in = 1'b1;
    idle(2);

    for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

    // 4-byte load: address walk and result timing
    go_work = 1'b1; l_or_s = 1'b0; width = 3'd4; address = 32'h100;
    tick();
    go_work = 1'b0;
    check("A mem_a E0", mem_a, 32'h100);
    check("A mem_wr E0", {31'b0, mem_wr}, 32'd0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      check($sformatf("A mem_a E%0d", k), mem_a, 32'h100 + k);
      check($sformatf("A early result E%0d", k), {31'b0, has_result}, 32'd0);
    end
    tick();
    check("A has_result E4", {31'b0, has_result}, 32'd1);
    check("A value E4", value_load, 32'h12345678);
    tick();
    check("A result pulse width", {31'b0, has_result}, 32'd0);
    idle(3);

    // go_work held: acceptance spacing set by the guard
    go_work = 1'b1; l_or_s = 1'b0; width = 3'd1; address = 32'h110;
    rpat = '0; cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      rpat = {rpat[4:0], received};
      if (has_result) cnt++;
    end
    go_work = 1'b0;
    check("B received pattern", {26'b0, rpat}, 32'b100100);
    check("B result count", cnt, 2);
    idle(4);

    // Simultaneous requests: LSB first, then fetch
    go_work = 1'b1; l_or_s = 1'b0; width = 3'd1; address = 32'h110;
    if_req = 1'b1; if_addr = 32'h0;
    tick();
    go_work = 1'b0;
    check("C lsb wins", {31'b0, received}, 32'd1);
    hr_tick = -1; ifd_tick = -1;
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (has_result && hr_tick < 0) hr_tick = i;
      if (if_done && ifd_tick < 0) begin
        ifd_tick = i;
        check("C if_data", if_data, 32'h00000013);
        if_req = 1'b0;
      end
    end
    if_req = 1'b0;
    check("C load done tick", hr_tick, 1);
    check("C fetch done tick", ifd_tick, 6);
    idle(2);

    // IO gating of a store
    io_buffer_full = 1'b1;
    go_work = 1'b1; l_or_s = 1'b1; width = 3'd1; address = 32'h30000; value_store = 32'hA5;
    tick();
    go_work = 1'b0;
    cnt = mem_wr ? 1 : 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (mem_wr) cnt++;
    end
    check("D gated writes", cnt, 0);
    io_buffer_full = 1'b0;
    tick();
    check("D write after release", {31'b0, mem_wr}, 32'd1);
    check("D write addr", mem_a, 32'h30000);
    check("D write data", {24'b0, mem_dout}, 32'hA5);
    tick();
    check("D write ends", {31'b0, mem_wr}, 32'd0);
    check("D ram", {24'b0, ram[18'h30000]}, 32'hA5);
    idle(3);

    // Flush mid-fetch, then LSB accepted straight away
    if_req = 1'b1; if_addr = 32'h100;
    tick();
    if_req = 1'b0;
    idle(2);
    clear_in = 1'b1;
    tick();
    clear_in = 1'b0;
    check("E no if_done at abort", {31'b0, if_done}, 32'd0);
    go_work = 1'b1; l_or_s = 1'b0; width = 3'd1; address = 32'h110;
    tick();
    go_work = 1'b0;
    check("E idle after abort", {31'b0, received}, 32'd1);
    cnt = 0; hr_tick = -1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (if_done) cnt++;
      if (has_result && hr_tick < 0) begin
        hr_tick = i;
        check("E load value", value_load, 32'hF0);
      end
    end
    check("E if_done count", cnt, 0);
    check("E load tick", hr_tick, 1);
    idle(2);

    // Pause mid-read
    go_work = 1'b1; l_or_s = 1'b0; width = 3'd4; address = 32'h100;
    tick();
    go_work = 1'b0;
    tick();
    rdy_in = 1'b0;
    idle(2);
    check("G mem_a held", mem_a, 32'h101);
    check("G no result in pause", {31'b0, has_result}, 32'd0);
    rdy_in = 1'b1;
    hr_tick = -1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (has_result && hr_tick < 0) begin
        hr_tick = i;
        check("G value", value_load, 32'h12345678);
      end
    end
    check("G resume latency", hr_tick, 4);
    idle(2);

    // Asynchronous reset mid-load
    go_work = 1'b1; l_or_s = 1'b0; width = 3'd4; address = 32'h100;
    tick();
    go_work = 1'b0;
    tick();
    rst_in = 1'b0;
    #1;
    check("F mem_a", mem_a, 32'd0);
    check("F strobes", {28'b0, received, has_result, if_done, mem_wr}, 32'd0);
    check("F value_load", value_load, 32'd0);
    check("F if_data", if_data, 32'd0);
    tick();
    rst_in = 1'b1;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (has_result) cnt++;
    end
    check("F no result after reset", cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
